// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: multiplexed 4-digit 7-segment driver with a per-frame digit snapshot,
// leading-zero blanking and per-digit decimal points.
module fnd_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   snap;
    logic [3:0]    snap_dp;
    logic          primed;
    logic          tick, wrap, load, lit, blank;
    logic [3:0]    nib, z, an_d;
    logic [6:0]    dec, seg_d;
    logic          dp_d;

    assign tick = en && presc == LAST;
    assign wrap = tick && idx == 2'd3;
    assign load = en && (!primed || wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            snap       <= '0;
            snap_dp    <= '0;
            primed     <= 1'b0;
            frame_done <= 1'b0;
            an         <= {4{ACTIVE_LOW}};
            seg        <= {7{ACTIVE_LOW}};
            dp         <= ACTIVE_LOW;
        end else begin
            if (en) begin
                presc  <= tick ? '0 : presc + 1'b1;
                primed <= 1'b1;
            end
            if (tick)
                idx <= idx + 2'd1;
            if (load) begin
                snap    <= digits;
                snap_dp <= dp_in;
            end
            frame_done <= wrap;
            an         <= an_d ^ {4{ACTIVE_LOW}};
            seg        <= seg_d ^ {7{ACTIVE_LOW}};
            dp         <= dp_d ^ ACTIVE_LOW;
        end
    end

    assign nib = snap[{idx, 2'b00} +: 4];

    always_comb begin
        dec = 7'h40;
        case (nib)
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    end

    // A digit blanks only when it and every digit above it are zero
    assign z     = {snap[15:12] == 4'd0, snap[11:8] == 4'd0, snap[7:4] == 4'd0, snap[3:0] == 4'd0};
    assign blank = BLANK_LZ && (idx == 2'd3 ? z[3] : idx == 2'd2 ? &z[3:2] : idx == 2'd1 ? &z[3:1] : 1'b0);
    assign lit   = en && primed;
    assign an_d  = lit ? 4'b0001 << idx : 4'b0000;
    assign seg_d = (lit && !blank) ? dec : 7'h00;
    assign dp_d  = lit && snap_dp[idx];
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of scan order, decode, blanking, snapshot, en and reset
// on an active-high and an active-low instance driven by the same inputs.
module tb_fnd_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    int          cyc = 0;
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    fnd_scan_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
        .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
    );

    fnd_scan_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_in(dp_in),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
        vectors++;
        assert ({an0, seg0, dp0, fd0} === {a, s, d, f})
        else begin
            errs++;
            $error("FAIL %s hi: an/seg/dp/fd observed %b/%h/%b/%b expected %b/%h/%b/%b", tag, an0, seg0, dp0, fd0, a, s, d, f);
        end
        vectors++;
        assert ({an1, seg1, dp1, fd1} === {~a, ~s, ~d, f})
        else begin
            errs++;
            $error("FAIL %s lo: an/seg/dp/fd observed %b/%h/%b/%b expected %b/%h/%b/%b", tag, an1, seg1, dp1, fd1, ~a, ~s, ~d, f);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'b0000, 7'h00, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        goto(1);  chk("prime", 4'b0000, 7'h00, 1'b0, 1'b0);
        goto(2);  chk("first_d0", 4'b0001, 7'h66, 1'b0, 1'b0);
        goto(4);  chk("d0_hold", 4'b0001, 7'h66, 1'b0, 1'b0);
        goto(5);  chk("d1", 4'b0010, 7'h4F, 1'b0, 1'b0);
        goto(8);  chk("d1_hold", 4'b0010, 7'h4F, 1'b0, 1'b0);
        goto(9);  chk("d2", 4'b0100, 7'h5B, 1'b0, 1'b0);
        goto(13); chk("d3", 4'b1000, 7'h06, 1'b0, 1'b0);
        goto(16); chk("wrap_fd", 4'b1000, 7'h06, 1'b0, 1'b1);
        goto(17); chk("f2_d0", 4'b0001, 7'h66, 1'b0, 1'b0);
        digits = 16'h0007;
        goto(32); chk("old_frame", 4'b1000, 7'h06, 1'b0, 1'b1);
        goto(33); chk("lz7_d0", 4'b0001, 7'h07, 1'b0, 1'b0);
        digits = 16'h0000;
        goto(37); chk("lz7_d1", 4'b0010, 7'h00, 1'b0, 1'b0);
        goto(41); chk("lz7_d2", 4'b0100, 7'h00, 1'b0, 1'b0);
        goto(45); chk("lz7_d3", 4'b1000, 7'h00, 1'b0, 1'b0);
        goto(49); chk("lz0_d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
        digits = 16'h1111;
        goto(53); chk("lz0_d1", 4'b0010, 7'h00, 1'b0, 1'b0);
        goto(61); chk("lz0_d3", 4'b1000, 7'h00, 1'b0, 1'b0);
        goto(65); chk("ones_d0", 4'b0001, 7'h06, 1'b0, 1'b0);
        goto(69); chk("ones_d1", 4'b0010, 7'h06, 1'b0, 1'b0);
        digits = 16'h2222;
        goto(73); chk("midchg_d2", 4'b0100, 7'h06, 1'b0, 1'b0);
        goto(77); chk("midchg_d3", 4'b1000, 7'h06, 1'b0, 1'b0);
        goto(80); chk("midchg_fd", 4'b1000, 7'h06, 1'b0, 1'b1);
        goto(81); chk("twos_d0", 4'b0001, 7'h5B, 1'b0, 1'b0);
        digits = 16'hA000;
        goto(85); chk("twos_d1", 4'b0010, 7'h5B, 1'b0, 1'b0);
        goto(97); chk("a000_d0", 4'b0001, 7'h3F, 1'b0, 1'b0);
        digits = 16'h8888;
        dp_in  = 4'b0100;
        goto(101); chk("a000_d1", 4'b0010, 7'h3F, 1'b0, 1'b0);
        goto(105); chk("a000_d2", 4'b0100, 7'h3F, 1'b0, 1'b0);
        goto(109); chk("a000_dash", 4'b1000, 7'h40, 1'b0, 1'b0);
        goto(113); chk("dp_d0", 4'b0001, 7'h7F, 1'b0, 1'b0);
        goto(117); chk("dp_d1", 4'b0010, 7'h7F, 1'b0, 1'b0);
        goto(121); chk("dp_d2", 4'b0100, 7'h7F, 1'b1, 1'b0);
        goto(122);
        en = 1'b0;
        goto(123); chk("en_off", 4'b0000, 7'h00, 1'b0, 1'b0);
        goto(132); chk("en_off_end", 4'b0000, 7'h00, 1'b0, 1'b0);
        en = 1'b1;
        goto(133); chk("resume_d2", 4'b0100, 7'h7F, 1'b1, 1'b0);
        goto(134); chk("resume_d2b", 4'b0100, 7'h7F, 1'b1, 1'b0);
        goto(135); chk("resume_d3", 4'b1000, 7'h7F, 1'b0, 1'b0);
        goto(137);
        en = 1'b0;
        goto(138); chk("no_tick_off", 4'b0000, 7'h00, 1'b0, 1'b0);
        en = 1'b1;
        goto(139); chk("late_wrap", 4'b1000, 7'h7F, 1'b0, 1'b1);
        goto(140); chk("late_d0", 4'b0001, 7'h7F, 1'b0, 1'b0);
        goto(149); chk("pre_rst_d2", 4'b0100, 7'h7F, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_async", 4'b0000, 7'h00, 1'b0, 1'b0);
        goto(151);
        rst = 1'b0;
        goto(152); chk("rst_prime", 4'b0000, 7'h00, 1'b0, 1'b0);
        goto(153); chk("rst_first_d0", 4'b0001, 7'h7F, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
